// File: rtl/wbuf_drain_pkg.sv
// Shared symbols for the write-buffer drain engine: FSM encoding, defaults, counter sizing.
package wbuf_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } state_t;

  localparam int MAXRETRY_DEF = 3;
  localparam int TIMEOUT_DEF  = 255;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/wbuf_timer.sv
// Saturating WAIT-cycle counter; expire is high once the count has reached TIMEOUT.
module wbuf_timer
  import wbuf_drain_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = cnt_width(TIMEOUT);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != TW'(TIMEOUT))) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/wbuf_drain.sv
// Drains the write-buffer head onto the bus: request, write, retry on error/timeout, retire.
// Entries that exhaust their retries are discarded and flagged on the sticky ERRO.
module wbuf_drain
  import wbuf_drain_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAXRETRY = MAXRETRY_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             CLOCKI,
  input  logic             RESETI,
  input  logic             FIFOVALIDI,
  input  logic             FIFONEWI,
  input  logic [WIDTH-1:0] ADDRI,
  input  logic [WIDTH-1:0] DATAI,
  input  logic             BUSGNTI,
  input  logic             BUSACKI,
  input  logic             BUSERRI,
  output logic             SHIFTO,
  output logic             BUSREQO,
  output logic             BUSWRO,
  output logic [WIDTH-1:0] BUSADDRO,
  output logic [WIDTH-1:0] BUSDATAO,
  output logic             BUSYO,
  output logic             ERRO,
  output logic [15:0]      COUNTO
);

  localparam int RW = cnt_width(MAXRETRY);

  state_t         state, state_nxt;
  logic [RW-1:0]  retry_q;
  logic           fnew_q;
  logic           pend_q;
  logic           stale;
  logic           grant;
  logic           retry_inc;
  logic           discard;
  logic           tmo_expire;
  logic           in_wait;

  // After a retire the head still shows the old entry until FIFONEWI toggles;
  // never re-request it in that window.
  assign stale   = pend_q && (FIFONEWI == fnew_q);
  assign in_wait = (state == ST_WAIT);

  wbuf_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (CLOCKI),
    .rst    (RESETI),
    .clear  (grant),
    .enable (in_wait),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    retry_inc = 1'b0;
    discard   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (FIFOVALIDI) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!FIFOVALIDI) begin
          state_nxt = ST_IDLE;
        end else if (!stale && BUSGNTI) begin
          grant     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (BUSACKI) begin
          state_nxt = ST_RETIRE;
        end else if (BUSERRI || tmo_expire) begin
          if (retry_q < RW'(MAXRETRY)) begin
            retry_inc = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            discard   = 1'b1;
            state_nxt = ST_RETIRE;
          end
        end
      end
      ST_RETIRE: begin
        state_nxt = FIFOVALIDI ? ST_REQ : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    SHIFTO  = 1'b0;
    BUSREQO = 1'b0;
    BUSWRO  = 1'b0;
    BUSYO   = 1'b0;
    if (!RESETI) begin
      SHIFTO  = (state == ST_RETIRE) && FIFOVALIDI;
      BUSREQO = ((state == ST_REQ) && FIFOVALIDI && !stale) || in_wait;
      BUSWRO  = in_wait;
      BUSYO   = (state != ST_IDLE);
    end
  end

  always_ff @(posedge CLOCKI) begin
    if (RESETI) begin
      state    <= ST_IDLE;
      retry_q  <= '0;
      fnew_q   <= 1'b0;
      pend_q   <= 1'b0;
      BUSADDRO <= '0;
      BUSDATAO <= '0;
      ERRO     <= 1'b0;
      COUNTO   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        BUSADDRO <= ADDRI;
        BUSDATAO <= DATAI;
        fnew_q   <= FIFONEWI;
      end
      if (state == ST_RETIRE) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + RW'(1);
      end
      if (discard) ERRO <= 1'b1;
      if (SHIFTO) begin
        COUNTO <= COUNTO + 16'd1;
        pend_q <= 1'b1;
      end else if (FIFONEWI != fnew_q) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wbuf_drain.sv
// Bench for wbuf_drain: FIFO-head model, scripted bus responder, scoreboard of retired entries.
module tb_wbuf_drain;

  localparam int W        = 32;
  localparam int TIMEOUT  = 255;
  localparam int R_ACK    = 0;
  localparam int R_ERR    = 1;
  localparam int R_TMO    = 2;
  localparam int R_BOTH   = 3;

  logic          clk = 1'b0;
  logic          rst, fvalid, fnew, gnt, ack, err;
  logic [W-1:0]  addr, data;
  logic          shift_o, req_o, wr_o, busy_o, err_o;
  logic [W-1:0]  baddr_o, bdata_o;
  logic [15:0]   count_o;

  always #5 clk = ~clk;

  wbuf_drain #(.WIDTH(W), .MAXRETRY(3), .TIMEOUT(TIMEOUT)) dut (
    .CLOCKI(clk), .RESETI(rst), .FIFOVALIDI(fvalid), .FIFONEWI(fnew),
    .ADDRI(addr), .DATAI(data), .BUSGNTI(gnt), .BUSACKI(ack), .BUSERRI(err),
    .SHIFTO(shift_o), .BUSREQO(req_o), .BUSWRO(wr_o), .BUSADDRO(baddr_o),
    .BUSDATAO(bdata_o), .BUSYO(busy_o), .ERRO(err_o), .COUNTO(count_o)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
    bit           disc;
  } ent_t;

  ent_t   fifo_q[$];
  ent_t   exp_q[$];
  int     resp_q[$];
  int     cur_resp;
  int     n_cmp, n_bad;
  int     n_shift, n_idle, n_wait, n_att;
  int     exp_cnt;
  bit     exp_err;
  bit     shift_seen, prev_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_head();
    fvalid = (fifo_q.size() > 0);
    addr   = fvalid ? fifo_q[0].a : '0;
    data   = fvalid ? fifo_q[0].d : '0;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] d, input bit disc);
    ent_t e;
    e.a = a; e.d = d; e.disc = disc;
    fifo_q.push_back(e);
    exp_q.push_back(e);
    drive_head();
  endtask

  // One clock: observe at negedge, drive responder, apply FIFO shift after the edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    shift_seen = 1'b0;
    if (shift_o) begin
      n_shift++;
      shift_seen = 1'b1;
      chk("shift_head_valid", fvalid, 1);
      chk("exp_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus_addr", baddr_o, e.a);
        chk("bus_data", bdata_o, e.d);
        if (e.disc) exp_err = 1'b1;
        chk("erro_at_shift", err_o, exp_err);
        chk("count_before", count_o, exp_cnt);
        exp_cnt++;
      end
    end
    if (!busy_o) n_idle++;
    if (wr_o) n_wait++;
    if (wr_o && !prev_wr) begin
      n_att++;
      cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
    end
    prev_wr = wr_o;
    gnt = req_o && !wr_o;
    ack = wr_o && (cur_resp == R_ACK || cur_resp == R_BOTH);
    err = wr_o && (cur_resp == R_ERR || cur_resp == R_BOTH);
    @(posedge clk);
    #1;
    if (shift_seen && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      fnew = ~fnew;
      drive_head();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete(); exp_q.delete(); resp_q.delete();
    fnew = 1'b0; gnt = 1'b0; ack = 1'b0; err = 1'b0;
    cur_resp = R_ACK; prev_wr = 1'b0;
    drive_head();
    repeat (2) tick();
    rst = 1'b0;
    exp_cnt = 0; exp_err = 1'b0;
    n_shift = 0; n_idle = 0; n_wait = 0; n_att = 0;
  endtask

  task automatic wait_shift(input int target, input int budget, output int ticks);
    ticks = 0;
    while (n_shift < target && ticks < budget) begin
      tick();
      ticks++;
    end
    chk("shift_count", n_shift, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift"}, shift_o, 0);
    chk({tag, "_req"},   req_o,   0);
    chk({tag, "_wr"},    wr_o,    0);
    chk({tag, "_busy"},  busy_o,  0);
    chk({tag, "_erro"},  err_o,   0);
    chk({tag, "_addr"},  baddr_o, 0);
    chk({tag, "_data"},  bdata_o, 0);
    chk({tag, "_count"}, count_o, 0);
  endtask

  initial begin
    int t, idle0, shifts0;
    n_cmp = 0; n_bad = 0;
    do_reset();
    chk_all_zero("reset");

    // Single entry, immediate grant and ACK: shift three cycles after valid rises.
    push(32'h1000, 32'hDEAD_BEEF, 1'b0);
    wait_shift(1, 20, t);
    chk("latency", t - 1, 3);
    repeat (3) tick();
    chk("single_addr", baddr_o, 32'h1000);
    chk("single_count", count_o, 1);
    chk("single_idle", busy_o, 0);

    // Four back-to-back entries with no IDLE between retires.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b0);
    wait_shift(1, 20, t);
    idle0 = n_idle;
    wait_shift(4, 40, t);
    chk("b2b_no_idle", n_idle - idle0, 0);
    repeat (3) tick();
    chk("b2b_count", count_o, 4);

    // Two bus errors, then ACK.
    do_reset();
    resp_q = '{R_ERR, R_ERR, R_ACK};
    push(32'h3000, 32'h1234_5678, 1'b0);
    wait_shift(1, 50, t);
    repeat (3) tick();
    chk("err2_attempts", n_att, 3);
    chk("err2_shifts", n_shift, 1);
    chk("err2_erro", err_o, 0);

    // ACK and ERR together: ACK wins.
    do_reset();
    resp_q = '{R_BOTH};
    push(32'h3800, 32'h0BAD_F00D, 1'b0);
    wait_shift(1, 20, t);
    repeat (2) tick();
    chk("both_attempts", n_att, 1);
    chk("both_erro", err_o, 0);

    // Four errors exhaust the retries: discarded, sticky error.
    do_reset();
    resp_q = '{R_ERR, R_ERR, R_ERR, R_ERR};
    push(32'h4000, 32'hCAFE_0001, 1'b1);
    wait_shift(1, 60, t);
    repeat (3) tick();
    chk("err4_attempts", n_att, 4);
    chk("err4_erro", err_o, 1);
    chk("err4_count", count_o, 1);

    // No response at all: each attempt spends 256 WAIT cycles (count 0..255) before expiry.
    do_reset();
    resp_q = '{R_TMO, R_TMO, R_TMO, R_TMO};
    push(32'h5000, 32'hFEED_FACE, 1'b1);
    wait_shift(1, 1200, t);
    repeat (3) tick();
    chk("tmo_attempts", n_att, 4);
    chk("tmo_wait_cycles", n_wait, 4 * (TIMEOUT + 1));
    chk("tmo_erro", err_o, 1);
    repeat (5) tick();
    chk("erro_sticky", err_o, 1);

    // Reset during WAIT aborts without a shift.
    do_reset();
    push(32'h6000, 32'h7777_7777, 1'b0);
    resp_q = '{R_TMO};
    t = 0;
    while (!wr_o && t < 20) begin
      tick();
      t++;
    end
    chk("reached_wait", wr_o, 1);
    shifts0 = n_shift;
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("midrst");
    chk("midrst_no_shift", n_shift, shifts0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbuf_drain.md
WBUF_DRAIN -- requirements
Module: wbuf_drain

Interface
REQ-001 Parameter WIDTH, default 32: address and data width of the head entry and the bus.
REQ-002 Parameter MAXRETRY, default 3: bus-error retries allowed per entry before it is discarded.
REQ-003 Parameter TIMEOUT, default 255: maximum number of WAIT cycles before an implicit error.
REQ-004 CLOCKI  in  1  single clock; every register updates on its rising edge.
REQ-005 RESETI  in  1  reset, synchronous, active-high.
REQ-006 FIFOVALIDI  in  1  head-entry valid flag from the FIFO controller's head-valid output.
REQ-007 FIFONEWI  in  1  head-change toggle from the FIFO controller.
REQ-008 ADDRI  in  WIDTH  head-entry address.
REQ-009 DATAI  in  WIDTH  head-entry data.
REQ-010 BUSGNTI  in  1  bus grant.
REQ-011 BUSACKI  in  1  write acknowledge.
REQ-012 BUSERRI  in  1  write error response.
REQ-013 SHIFTO  out  1  one-cycle retire pulse, connected to the FIFO controller's shift input.
REQ-014 BUSREQO  out  1  bus request.
REQ-015 BUSWRO  out  1  write strobe.
REQ-016 BUSADDRO  out  WIDTH  latched write address.
REQ-017 BUSDATAO  out  WIDTH  latched write data.
REQ-018 BUSYO  out  1  high whenever the FSM is not in IDLE.
REQ-019 ERRO  out  1  sticky flag: an entry was discarded.
REQ-020 COUNTO  out  16  count of retired entries.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, RETIRE.
REQ-022 IDLE: when FIFOVALIDI=1, the FSM shall move to REQ on the next edge.
REQ-023 REQ: BUSREQO=1.
REQ-024 REQ, on BUSGNTI=1: ADDRI and DATAI shall be latched into BUSADDRO and BUSDATAO, the timeout counter cleared, and the FSM shall move to WAIT.
REQ-025 WAIT: BUSWRO=1 and BUSREQO=1; BUSADDRO and BUSDATAO shall be held stable.
REQ-026 WAIT, on BUSACKI=1: the FSM shall move to RETIRE.
REQ-027 If BUSACKI and BUSERRI are both high in the same cycle, ACK shall win.
REQ-028 WAIT, on BUSERRI=1 (or timeout reaching TIMEOUT) with retry count < MAXRETRY: the retry count shall increment and the FSM shall return to REQ.
REQ-029 WAIT, on BUSERRI=1 (or timeout) with retry count = MAXRETRY: ERRO shall be set and the FSM shall move to RETIRE, discarding the entry.
REQ-030 RETIRE: SHIFTO=1 for exactly one cycle, retry count cleared, COUNTO incremented (wraps 0xFFFF to 0); next state is REQ if FIFOVALIDI=1 after the shift is seen, otherwise IDLE.
REQ-031 RETIRE: the next-state decision shall use a FIFONEWI toggle relative to its value captured at grant; with no toggle and FIFOVALIDI=0, the next state is IDLE.
REQ-032 SHIFTO shall never be asserted while FIFOVALIDI=0.
REQ-033 Minimum latency FIFOVALIDI rise to SHIFTO is 3 cycles, given grant in the first REQ cycle and ACK in the first WAIT cycle.
REQ-034 BUSGNTI, BUSACKI and BUSERRI shall be ignored in states where they are not expected.
REQ-035 The timeout counter saturates, is 8 bits wide for the default TIMEOUT, and counts only in WAIT.

Reset
REQ-036 While RESETI=1: state=IDLE; SHIFTO, BUSREQO, BUSWRO, BUSYO, ERRO = 0; BUSADDRO, BUSDATAO, COUNTO, retry count, timeout count = 0.
REQ-037 Reset asserted mid-transaction shall abort on the next edge without a SHIFTO pulse.
REQ-038 ERRO shall be cleared only by reset.

Structure
REQ-039 State encodings, MAXRETRY and TIMEOUT defaults shall live in the shared symbols include file.
REQ-040 The timeout counter shall be a sub-module wbuf_timer (clear, enable, expire output).

Verification
REQ-041 Single entry, grant and ACK in the first cycle, ADDRI=0x1000, DATAI=0xDEADBEEF -> SHIFTO in cycle 3, BUSADDRO=0x1000, COUNTO=1.
REQ-042 Four back-to-back entries -> four SHIFTO pulses, no IDLE cycle between them, COUNTO=4.
REQ-043 BUSERRI twice, then ACK -> two re-requests, one SHIFTO, ERRO=0.
REQ-044 BUSERRI four times (MAXRETRY=3) -> SHIFTO once, ERRO=1, COUNTO=1.
REQ-045 No ACK for 255 cycles, repeated on every retry -> entry discarded, ERRO=1.
REQ-046 RESETI during WAIT -> next cycle all outputs 0 and no SHIFTO pulse.
